decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 271 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RISC-V decode stage: combinational decode of instr, captured into a
// two-entry (main + skid) buffer with valid/ready handshakes on both sides.
//
// state | meaning
// EMPTY | no bundle buffered, out_valid low
// ONE   | main register holds the presented bundle
// TWO   | main presented, skid holds the next bundle, in_ready low
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       ra1,
  output logic [4:0]       ra2,
  output logic [4:0]       wa3,
  output logic [2:0]       funct3,
  output logic             funct7,
  output logic             word,
  output logic             src1_selector,
  output logic             src2_selector,
  output logic             wd3_selector,
  output logic             we3,
  output logic             wem,
  output logic             illegal,
  output logic [CNT_W-1:0] decode_count
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam bit IS_RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [4:0]      wa3;
    logic [2:0]      funct3;
    logic            funct7;
    logic            word;
    logic            src1_sel;
    logic            src2_sel;
    logic            wd3_sel;
    logic            we3;
    logic            wem;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t  state, state_next;
  bundle_t dec, main_q, skid_q;
  logic    push, pop;

  // ---------------- combinational decode ----------------
  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic signed [31:0] imm32;
  logic known, uses_rs1, uses_rs2, writes_rd, is_store, is_word, bad_f7, bad_shift, bad;

  always_comb begin
    opcode    = instr[6:0];
    f3        = instr[14:12];
    f7        = instr[31:25];
    imm32     = '0;
    known     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_store  = 1'b0;
    is_word   = 1'b0;
    bad_f7    = 1'b0;
    bad_shift = 1'b0;
    dec       = '0;

    case (opcode)
      OPC_OP_IMM: begin
        known        = 1'b1;
        uses_rs1     = 1'b1;
        writes_rd    = 1'b1;
        dec.src2_sel = 1'b1;
        imm32        = {{20{instr[31]}}, instr[31:20]};
        // RV32 shift amounts are 5 bits; instr[25] would be shamt[5]
        bad_shift    = !IS_RV64 && (f3 == 3'b001 || f3 == 3'b101) && instr[25];
      end
      OPC_OP_IMM_32: begin
        uses_rs1 = 1'b1;
        if (IS_RV64) begin
          known        = 1'b1;
          writes_rd    = 1'b1;
          is_word      = 1'b1;
          dec.src2_sel = 1'b1;
          imm32        = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_OP, OPC_OP_32: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (opcode == OPC_OP || IS_RV64) begin
          known     = 1'b1;
          writes_rd = 1'b1;
          is_word   = (opcode == OPC_OP_32);
          bad_f7    = (f7 != 7'b0000000 && f7 != 7'b0100000) ||
                      (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101);
        end
      end
      OPC_LUI: begin
        known        = 1'b1;
        writes_rd    = 1'b1;
        dec.src2_sel = 1'b1;
        imm32        = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        known        = 1'b1;
        writes_rd    = 1'b1;
        dec.src1_sel = 1'b1;
        dec.src2_sel = 1'b1;
        imm32        = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        known        = 1'b1;
        writes_rd    = 1'b1;
        dec.src1_sel = 1'b1;
        dec.src2_sel = 1'b1;
        imm32        = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        known        = 1'b1;
        uses_rs1     = 1'b1;
        writes_rd    = 1'b1;
        dec.src1_sel = 1'b1;
        dec.src2_sel = 1'b1;
        imm32        = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_BRANCH: begin
        known    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LOAD: begin
        known        = 1'b1;
        uses_rs1     = 1'b1;
        writes_rd    = 1'b1;
        dec.src2_sel = 1'b1;
        dec.wd3_sel  = 1'b1;
        imm32        = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        known        = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        is_store     = 1'b1;
        dec.src2_sel = 1'b1;
        imm32        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_MISC_MEM, OPC_SYSTEM: known = 1'b1;
      default: ;
    endcase

    bad = (instr[1:0] != 2'b11) || !known || bad_f7 || bad_shift;

    dec.pc      = pc_in;
    dec.imm     = bad ? '0 : XLEN'(imm32);
    dec.ra1     = uses_rs1 ? instr[19:15] : 5'd0;
    dec.ra2     = uses_rs2 ? instr[24:20] : 5'd0;
    dec.wa3     = instr[11:7];
    dec.funct3  = f3;
    dec.funct7  = instr[30];
    dec.word    = is_word;
    dec.we3     = writes_rd && !bad && (instr[11:7] != 5'd0);
    dec.wem     = is_store && !bad;
    dec.illegal = bad;
  end

  // ---------------- buffer control FSM ----------------
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_next = ONE;
        ONE:     if (push && !pop) state_next = TWO;
                 else if (pop && !push) state_next = EMPTY;
        TWO:     if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
  end

  // ---------------- storage and counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      decode_count <= '0;
    end else begin
      if (!flush) begin
        case (state)
          EMPTY: if (push) main_q <= dec;
          ONE: begin
            if (push && pop) main_q <= dec;
            else if (push)   skid_q <= dec;
          end
          TWO: if (pop) main_q <= skid_q;
          default: ;
        endcase
      end
      if (pop) decode_count <= decode_count + CNT_W'(1);
    end
  end

  assign pc_out        = main_q.pc;
  assign imm           = main_q.imm;
  assign ra1           = main_q.ra1;
  assign ra2           = main_q.ra2;
  assign wa3           = main_q.wa3;
  assign funct3        = main_q.funct3;
  assign funct7        = main_q.funct7;
  assign word          = main_q.word;
  assign src1_selector = main_q.src1_sel;
  assign src2_selector = main_q.src2_sel;
  assign wd3_selector  = main_q.wd3_sel;
  assign we3           = main_q.we3;
  assign wem           = main_q.wem;
  assign illegal       = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32 instance (32-bit counter) and an
// RV64 instance (4-bit counter) share one input stream.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr, pc;

  logic        in_ready_a, out_valid_a, funct7_a, word_a, s1_a, s2_a, wd_a, we3_a, wem_a, ill_a;
  logic [31:0] pc_out_a, imm_a, cnt_a;
  logic [4:0]  ra1_a, ra2_a, wa3_a;
  logic [2:0]  f3_a;

  logic        in_ready_b, out_valid_b, funct7_b, word_b, s1_b, s2_b, wd_b, we3_b, wem_b, ill_b;
  logic [63:0] pc_out_b, imm_b;
  logic [3:0]  cnt_b;
  logic [4:0]  ra1_b, ra2_b, wa3_b;
  logic [2:0]  f3_b;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .pc_in(pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .pc_out(pc_out_a), .imm(imm_a), .ra1(ra1_a), .ra2(ra2_a), .wa3(wa3_a),
    .funct3(f3_a), .funct7(funct7_a), .word(word_a), .src1_selector(s1_a),
    .src2_selector(s2_a), .wd3_selector(wd_a), .we3(we3_a), .wem(wem_a),
    .illegal(ill_a), .decode_count(cnt_a));

  decode_stage #(.XLEN(64), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .pc_in({32'h0, pc}), .out_valid(out_valid_b), .out_ready(out_ready),
    .pc_out(pc_out_b), .imm(imm_b), .ra1(ra1_b), .ra2(ra2_b), .wa3(wa3_b),
    .funct3(f3_b), .funct7(funct7_b), .word(word_b), .src1_selector(s1_b),
    .src2_selector(s2_b), .wd3_selector(wd_b), .we3(we3_b), .wem(wem_b),
    .illegal(ill_b), .decode_count(cnt_b));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  ra1, ra2, wa3;
    logic [4:0]  ctl;   // {src1, src2, wd3, we3, wem}
    logic        ill;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    instr    = i;
    pc       = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{32'h00500093, 32'h00000005, 5'd0, 5'd0, 5'd1,  5'b01010, 1'b0}; // addi x1,x0,5
    vt[1]  = '{32'h00000013, 32'h00000000, 5'd0, 5'd0, 5'd0,  5'b01000, 1'b0}; // nop
    vt[2]  = '{32'h00000000, 32'h00000000, 5'd0, 5'd0, 5'd0,  5'b00000, 1'b1};
    vt[3]  = '{32'hFFC12283, 32'hFFFFFFFC, 5'd2, 5'd0, 5'd5,  5'b01110, 1'b0}; // lw x5,-4(x2)
    vt[4]  = '{32'h00612423, 32'h00000008, 5'd2, 5'd6, 5'd8,  5'b01001, 1'b0}; // sw x6,8(x2)
    vt[5]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 5'b00000, 1'b0}; // beq x1,x2,-8
    vt[6]  = '{32'h123451B7, 32'h12345000, 5'd0, 5'd0, 5'd3,  5'b01010, 1'b0}; // lui
    vt[7]  = '{32'h80000217, 32'h80000000, 5'd0, 5'd0, 5'd4,  5'b11010, 1'b0}; // auipc
    vt[8]  = '{32'h001000EF, 32'h00000800, 5'd0, 5'd0, 5'd1,  5'b11010, 1'b0}; // jal x1,2048
    vt[9]  = '{32'h00008067, 32'h00000000, 5'd1, 5'd0, 5'd0,  5'b11000, 1'b0}; // jalr x0,0(x1)
    vt[10] = '{32'h402081B3, 32'h00000000, 5'd1, 5'd2, 5'd3,  5'b00010, 1'b0}; // sub
    vt[11] = '{32'h402091B3, 32'h00000000, 5'd1, 5'd2, 5'd3,  5'b00000, 1'b1}; // f7=0100000,f3=001
    vt[12] = '{32'h022081B3, 32'h00000000, 5'd1, 5'd2, 5'd3,  5'b00000, 1'b1}; // f7=0000001
    vt[13] = '{32'h02009093, 32'h00000000, 5'd1, 5'd0, 5'd1,  5'b01000, 1'b1}; // slli shamt=32
    vt[14] = '{32'hFFF0809B, 32'h00000000, 5'd1, 5'd0, 5'd1,  5'b00000, 1'b1}; // addiw on RV32

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0;
    tick(); tick();
    reset = 1'b0;

    chk("reset out_valid", out_valid_a, 0);
    chk("reset in_ready",  in_ready_a,  1);
    chk("reset count",     cnt_a,       0);
    chk("reset imm",       imm_a,       0);
    chk("reset pc_out",    pc_out_a,    0);

    // single-entry decode table, drained one cycle after acceptance
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(vt[i].instr, 32'h1000 + 32'(4 * i));
      chk($sformatf("v%0d out_valid", i), out_valid_a, 1);
      chk($sformatf("v%0d pc_out", i),    pc_out_a,    32'h1000 + 32'(4 * i));
      chk($sformatf("v%0d imm", i),       imm_a,       vt[i].imm);
      chk($sformatf("v%0d ra1", i),       ra1_a,       vt[i].ra1);
      chk($sformatf("v%0d ra2", i),       ra2_a,       vt[i].ra2);
      chk($sformatf("v%0d wa3", i),       wa3_a,       vt[i].wa3);
      chk($sformatf("v%0d ctl", i),       {s1_a, s2_a, wd_a, we3_a, wem_a}, vt[i].ctl);
      chk($sformatf("v%0d illegal", i),   ill_a,       vt[i].ill);
      tick();
      exp_cnt++;
    end
    chk("table drained", out_valid_a, 0);
    chk("table count",   cnt_a,       exp_cnt);

    // RV64 word op and RV32/RV64 shift-amount boundary
    send(32'hFFF0809B, 32'h2000);
    chk("rv64 addiw word",    word_b,  1);
    chk("rv64 addiw imm",     imm_b,   64'hFFFF_FFFF_FFFF_FFFF);
    chk("rv64 addiw illegal", ill_b,   0);
    chk("rv64 addiw we3",     we3_b,   1);
    chk("rv64 addiw src2",    s2_b,    1);
    chk("rv32 addiw illegal", ill_a,   1);
    chk("rv32 addiw we3",     we3_a,   0);
    tick(); exp_cnt++;
    send(32'h02009093, 32'h2004);
    chk("rv64 slli32 illegal", ill_b,  0);
    chk("rv64 slli32 imm",     imm_b,  64'h20);
    chk("rv32 slli32 illegal", ill_a,  1);
    tick(); exp_cnt++;

    // backpressure: two accepted, third stalls until one drain
    out_ready = 1'b0;
    instr = 32'h00500093; in_valid = 1'b1;
    pc = 32'h3000; tick();
    chk("bp first accepted", out_valid_a, 1);
    pc = 32'h3004; tick();
    pc = 32'h3008;
    chk("bp in_ready full", in_ready_a, 0);
    chk("bp head pc",       pc_out_a,   32'h3000);
    tick();
    chk("bp stall stable pc", pc_out_a,   32'h3000);
    chk("bp stall in_ready",  in_ready_a, 0);
    chk("bp stall count",     cnt_a,      exp_cnt);
    out_ready = 1'b1;
    tick(); exp_cnt++;
    chk("bp second pc",     pc_out_a,   32'h3004);
    chk("bp in_ready back", in_ready_a, 1);
    tick(); exp_cnt++;
    in_valid = 1'b0;
    chk("bp third pc", pc_out_a, 32'h3008);
    tick(); exp_cnt++;
    chk("bp drained",  out_valid_a, 0);
    chk("bp count",    cnt_a,       exp_cnt);

    // flush in TWO with simultaneous input and output handshakes
    out_ready = 1'b0;
    send(32'h00500093, 32'h4000);
    send(32'h00500093, 32'h4004);
    chk("fl full", in_ready_a, 0);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; pc = 32'h4008;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl out_valid", out_valid_a, 0);
    chk("fl in_ready",  in_ready_a,  1);
    chk("fl count",     cnt_a,       exp_cnt);
    tick();
    chk("fl dropped input", out_valid_a, 0);

    // reset with flush while holding an entry
    out_ready = 1'b0;
    send(32'h00500093, 32'h5000);
    chk("rst pre out_valid", out_valid_a, 1);
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    chk("rst count",     cnt_a,       0);
    chk("rst out_valid", out_valid_a, 0);
    chk("rst in_ready",  in_ready_a,  1);
    chk("rst imm",       imm_a,       0);
    chk("rst wa3",       wa3_a,       0);
    chk("rst pc_out",    pc_out_a,    0);
    chk("rst cnt64",     cnt_b,       0);

    // 4-bit counter wrap on the RV64 instance
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(32'h00500093, 32'h6000 + 32'(4 * i));
      tick();
      if (i == 14) chk("wrap cnt 15", cnt_b, 4'd15);
    end
    chk("wrap cnt64", cnt_b, 4'd0);
    chk("wrap cnt32", cnt_a, 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
